// File: rtl/mp_shift_acc_pkg.sv
// Shared types and helpers for the mp_shift_acc digit-serial shift-accumulate stage.
// Holds the FSM state encoding and the minimum-accumulator-width rule.
package mp_shift_acc_pkg;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Widest aligned term is an N-bit value shifted by up to 2^S-1 places.
    function automatic int min_acc_w(input int n, input int s);
        return n + (1 << s) - 1;
    endfunction

endpackage

// File: rtl/mp_lsf.sv
// Dynamic logical left shifter, log2 stages; bits shifted past the MSB are dropped.
// Latency: combinational.
// Backpressure: none, pure datapath.
module mp_lsf #(
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic [N-1:0] src,
    input  logic [S-1:0] amt,
    output logic [N-1:0] res
);

    always_comb begin
        res = src;
        for (int i = 0; i < S; i++) begin
            if (amt[i]) begin
                res = res << (1 << i);
            end
        end
    end

endmodule

// File: rtl/mp_shift_acc.sv
// Digit-serial shift-accumulate: sums sign-extended, left-shifted partial products per in_last group.
// Latency: result 1 cycle after the last beat (2 cycles with MP_SHIFT_ACC_PIPE_EN input register).
// Backpressure: result held in HOLD until out_ready; input ready passes out_ready through while holding.
module mp_shift_acc
    import mp_shift_acc_pkg::*;
#(
    parameter int N     = 8,
    parameter int S     = 3,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [S-1:0]     in_shift,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_cnt
);

    generate
        if (ACC_W < min_acc_w(N, S)) begin : g_bad_acc_w
            $error("mp_shift_acc: ACC_W must be at least N + 2**S - 1");
        end
    endgenerate

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   beat_cnt;

    logic               beat_vld;
    logic [N-1:0]       beat_dat;
    logic [S-1:0]       beat_shift;
    logic               beat_last;
    logic               beat_rdy;
    logic               beat_fire;

    // The accumulator can take a beat whenever no result is pending, or the pending one leaves now.
    assign beat_rdy = (state == ACC) || out_ready;

`ifdef MP_SHIFT_ACC_PIPE_EN
    logic               pipe_valid;
    logic [N-1:0]       pipe_data;
    logic [S-1:0]       pipe_shift;
    logic               pipe_last;
    logic               pipe_can_drain;

    assign pipe_can_drain = beat_rdy;
    assign in_ready       = !pipe_valid || pipe_can_drain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
            pipe_shift <= '0;
            pipe_last  <= 1'b0;
        end else if (in_ready) begin
            pipe_valid <= in_valid;
            if (in_valid) begin
                pipe_data  <= in_data;
                pipe_shift <= in_shift;
                pipe_last  <= in_last;
            end
        end
    end

    assign beat_vld   = pipe_valid;
    assign beat_dat   = pipe_data;
    assign beat_shift = pipe_shift;
    assign beat_last  = pipe_last;
`else
    assign in_ready   = beat_rdy;
    assign beat_vld   = in_valid;
    assign beat_dat   = in_data;
    assign beat_shift = in_shift;
    assign beat_last  = in_last;
`endif

    assign beat_fire = beat_vld && beat_rdy;

    logic [ACC_W-1:0]   term_ext;
    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_inc;

    assign term_ext = {{(ACC_W-N){beat_dat[N-1]}}, beat_dat};

    mp_lsf #(
        .N (ACC_W),
        .S (S)
    ) u_lsf (
        .src (term_ext),
        .amt (beat_shift),
        .res (term)
    );

    assign acc_next = (beat_cnt == '0) ? term : acc + term;
    assign cnt_inc  = (beat_cnt == {CNT_W{1'b1}}) ? beat_cnt : beat_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
        end else if (beat_fire) begin
            if (beat_last) begin
                out_data  <= acc_next;
                out_cnt   <= cnt_inc;
                out_valid <= 1'b1;
                acc       <= '0;
                beat_cnt  <= '0;
                state     <= HOLD;
            end else begin
                acc       <= acc_next;
                beat_cnt  <= cnt_inc;
                // A fire while holding implies out_ready, so the old result has left.
                out_valid <= 1'b0;
                state     <= ACC;
            end
        end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
        end
    end

endmodule

// File: tb/tb_mp_shift_acc.sv
// Directed self-checking bench for mp_shift_acc; build with MP_SHIFT_ACC_PIPE_EN for the registered-input variant.
module tb_mp_shift_acc;

    localparam int N     = 8;
    localparam int S     = 3;
    localparam int ACC_W = 24;
    localparam int CNT_W = 8;
    localparam int NGRP  = 256;
`ifdef MP_SHIFT_ACC_PIPE_EN
    localparam int LAT      = 2;
    localparam int HOLD_RDY = 1;
`else
    localparam int LAT      = 1;
    localparam int HOLD_RDY = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [S-1:0]     in_shift;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    logic [ACC_W-1:0] exp_q[$];
    bit               stream_done;
    bit               rnd_rdy;

    always #5 clk = ~clk;

    mp_shift_acc #(.N(N), .S(S), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] term_of(input logic [N-1:0] d, input logic [S-1:0] sh);
        int v;
        logic [31:0] w;
        v = $signed(d);
        v = v <<< sh;
        w = v;
        return w[ACC_W-1:0];
    endfunction

    // Called at a negedge; returns at the negedge after the beat was taken.
    task automatic send_beat(input logic [N-1:0] d, input logic [S-1:0] sh, input logic last,
                             output int stalls);
        bit ok;
        stalls   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shift = sh;
        in_last  = last;
        ok       = 1'b0;
        while (!ok) begin
            #1;
            ok = in_ready;
            if (!ok) stalls++;
            @(negedge clk);
            if (stalls > 200) begin
                chk("beat_timeout", 32'(stalls), 0);
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [ACC_W-1:0] ed, input logic [CNT_W-1:0] ec);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_vld"},  32'(out_valid), 1);
        chk({tag, "_data"}, 32'(out_data),  32'(ed));
        chk({tag, "_cnt"},  32'(out_cnt),   32'(ec));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic stream(input bit rnd, input string tag);
        int got;
        int bubbles;
        stream_done = 1'b0;
        rnd_rdy     = rnd;
        out_ready   = 1'b1;
        got         = 0;
        bubbles     = 0;
        fork
            begin
                int st;
                for (int g = 0; g < NGRP; g++) begin
                    logic [N-1:0]     d[3];
                    logic [S-1:0]     sh[3];
                    logic [ACC_W-1:0] sum;
                    sum = '0;
                    for (int b = 0; b < 3; b++) begin
                        d[b]  = N'($urandom_range(0, 255));
                        sh[b] = S'($urandom_range(0, 7));
                        sum   = sum + term_of(d[b], sh[b]);
                    end
                    exp_q.push_back(sum);
                    for (int b = 0; b < 3; b++) begin
                        send_beat(d[b], sh[b], b == 2, st);
                        bubbles += st;
                    end
                end
            end
            begin
                for (int c = 0; c < 20000 && got < NGRP; c++) begin
                    @(negedge clk);
                    #2;
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk({tag, "_spurious"}, 1, 0);
                        end else begin
                            chk({tag, "_data"}, 32'(out_data), 32'(exp_q.pop_front()));
                            chk({tag, "_cnt"},  32'(out_cnt),  3);
                        end
                        got++;
                    end
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(negedge clk);
                    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
        join
        out_ready = 1'b0;
        chk({tag, "_count"}, 32'(got), NGRP);
        if (!rnd) chk({tag, "_bubbles"}, 32'(bubbles), 0);
    endtask

    initial begin
        int st;
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_cnt",   32'(out_cnt),   0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  1);

        // Test 1: single-beat group and its latency
        send_beat(8'h05, 3'd3, 1'b1, st);
        k = 1;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t1_latency", 32'(k), LAT);
        wait_result("t1", 24'h000028, 8'd1);
        chk("t1_drained", 32'(out_valid), 0);

        // Test 2: sign extension before the shift
        send_beat(8'hFF, 3'd0, 1'b0, st);
        send_beat(8'hFF, 3'd7, 1'b1, st);
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t2_data", 32'(out_data), 32'h00FFFF7F);
        chk("t2_cnt",  32'(out_cnt),  2);

        // Test 3: hold under backpressure, then release together with a new beat
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("t3_hold_vld",  32'(out_valid), 1);
            chk("t3_hold_data", 32'(out_data),  32'h00FFFF7F);
            chk("t3_hold_cnt",  32'(out_cnt),   2);
            chk("t3_in_ready",  32'(in_ready),  HOLD_RDY);
        end
        out_ready = 1'b1;
        send_beat(8'h01, 3'd0, 1'b1, st);
        out_ready = 1'b0;
        chk("t3_accept_stall", 32'(st), 0);
`ifndef MP_SHIFT_ACC_PIPE_EN
        chk("t3_vld_stays", 32'(out_valid), 1);
`endif
        wait_result("t3", 24'h000001, 8'd1);

        // Test 4: reset in the middle of a group
        send_beat(8'h10, 3'd0, 1'b0, st);
        send_beat(8'h10, 3'd0, 1'b0, st);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_vld",  32'(out_valid), 0);
        chk("t4_rst_data", 32'(out_data),  0);
        chk("t4_rst_cnt",  32'(out_cnt),   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(8'h02, 3'd0, 1'b1, st);
        wait_result("t4", 24'h000002, 8'd1);

        // Beat counter saturates at all-ones
        for (int i = 0; i < 300; i++) begin
            send_beat(8'h01, 3'd0, i == 299, st);
        end
        wait_result("sat", 24'd300, 8'd255);

        // Test 5: streaming, full-rate then random backpressure
        stream(1'b0, "t5a");
        stream(1'b1, "t5b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
